// File: rtl/mem_slot_if.sv
// Bus bundle between the CPU/video/DIO side and the memory slot scheduler.
// The slave modport is the scheduler; the master modport is the surrounding system.
interface mem_slot_if #(
   parameter int ADDR_W  = 22,
   parameter int NUM_DIO = 2
);
   logic                        cep;
   logic                        turbo;
   logic                        cfg_rom_128k;
   logic [1:0]                  cfg_ram_size;
   logic [23:0]                 cpu_addr;
   logic                        cpu_uds_n;
   logic                        cpu_lds_n;
   logic                        cpu_rw;
   logic                        sel_ram;
   logic                        sel_rom;
   logic                        vblank_n;
   logic                        hblank_n;
   logic                        snd_alt;
   logic [NUM_DIO-1:0]          dio_req;
   logic [NUM_DIO*ADDR_W-1:0]   dio_addr;
   logic [NUM_DIO-1:0]          dio_ack;
   logic [1:0]                  slot;
   logic                        cpu_bus_ctl;
   logic                        dio_bus_ctl;
   logic                        load_sound;
   logic [ADDR_W-1:0]           mem_addr;
   logic                        mem_uds_n;
   logic                        mem_lds_n;
   logic                        rom_oe_n;
   logic                        ram_oe_n;
   logic                        ram_we_n;

   modport slave (
      input  cep, turbo, cfg_rom_128k, cfg_ram_size, cpu_addr, cpu_uds_n, cpu_lds_n, cpu_rw,
             sel_ram, sel_rom, vblank_n, hblank_n, snd_alt, dio_req, dio_addr,
      output dio_ack, slot, cpu_bus_ctl, dio_bus_ctl, load_sound, mem_addr,
             mem_uds_n, mem_lds_n, rom_oe_n, ram_oe_n, ram_we_n
   );

   modport master (
      output cep, turbo, cfg_rom_128k, cfg_ram_size, cpu_addr, cpu_uds_n, cpu_lds_n, cpu_rw,
             sel_ram, sel_rom, vblank_n, hblank_n, snd_alt, dio_req, dio_addr,
      input  dio_ack, slot, cpu_bus_ctl, dio_bus_ctl, load_sound, mem_addr,
             mem_uds_n, mem_lds_n, rom_oe_n, ram_oe_n, ram_we_n
   );
endinterface

// File: rtl/mem_slot_scheduler.sv
// Four-slot time-division scheduler for sound, CPU and arbitrated DIO reads into shared RAM/ROM.
// Define DIO_FIXED_PRIO_EN for fixed lowest-index DIO priority instead of round-robin.
module mem_slot_scheduler #(
   parameter int          ADDR_W        = 22,
   parameter int          NUM_DIO       = 2,
   parameter logic [21:0] DIO_BASE_STEP = 22'h100000,
   parameter logic [21:0] SND_MAIN      = 22'h3FFD00,
   parameter logic [21:0] SND_ALT       = 22'h3FA100
) (
   input logic       clk,
   input logic       reset,
   mem_slot_if.slave bus
);
   localparam int GW = (NUM_DIO > 1) ? $clog2(NUM_DIO) : 1;

   logic [1:0]        slot_q, slot_d;
   logic              vbd_q, vbd_d, hbd_q, hbd_d;
   logic              swap_q, swap_d, audio_req_q, audio_req_d;
   logic [ADDR_W-1:0] snd_addr_q, snd_addr_d;
   logic              gnt_vld_q, gnt_vld_d;
   logic [GW-1:0]     gnt_q, gnt_d;
`ifndef DIO_FIXED_PRIO_EN
   logic [GW-1:0]     last_q, last_d;
   int                idx;
`endif
   logic              pick_vld;
   logic [GW-1:0]     pick;
   logic              vb_fall, hb_fall, cpu_ctl, load_snd;
   logic [ADDR_W-1:0] dio_a, dio_off;
   logic              unused_cpu_hi;

   function automatic logic [21:0] mask_ram(input logic [21:0] a, input logic [1:0] sz);
      case (sz)
         2'd0:    mask_ram = {5'b0, a[16:0]};
         2'd1:    mask_ram = {3'b0, a[18:0]};
         2'd2:    mask_ram = {2'b0, a[19:0]};
         default: mask_ram = a;
      endcase
   endfunction

   function automatic logic [21:0] mask_rom(input logic [21:0] a, input logic rom128);
      mask_rom = rom128 ? {5'b0, a[16:0]} : {4'b0, 1'b1, 1'b0, a[15:0]};
   endfunction

   assign vb_fall       = vbd_q & ~bus.vblank_n;
   assign hb_fall       = hbd_q & ~bus.hblank_n;
   assign unused_cpu_hi = ^bus.cpu_addr[23:22];

   // Arbiter: later loop iterations override, so the lowest search distance wins.
   always_comb begin
      pick_vld = 1'b0;
      pick     = '0;
`ifdef DIO_FIXED_PRIO_EN
      for (int i = NUM_DIO - 1; i >= 0; i--) begin
         if (bus.dio_req[GW'(i)]) begin
            pick_vld = 1'b1;
            pick     = GW'(i);
         end
      end
`else
      idx = 0;
      for (int k = NUM_DIO; k >= 1; k--) begin
         idx = (int'(last_q) + k) % NUM_DIO;
         if (bus.dio_req[GW'(idx)]) begin
            pick_vld = 1'b1;
            pick     = GW'(idx);
         end
      end
`endif
   end

   always_comb begin
      slot_d      = slot_q;
      vbd_d       = vbd_q;
      hbd_d       = hbd_q;
      swap_d      = swap_q;
      audio_req_d = audio_req_q;
      snd_addr_d  = snd_addr_q;
      gnt_vld_d   = gnt_vld_q;
      gnt_d       = gnt_q;
`ifndef DIO_FIXED_PRIO_EN
      last_d      = last_q;
`endif
      if (bus.cep) begin
         slot_d = slot_q + 2'd1;
         case (slot_q)
            2'd0: begin
               vbd_d       = bus.vblank_n;
               hbd_d       = bus.hblank_n;
               audio_req_d = hb_fall;
               if (hb_fall && (swap_q || vb_fall)) begin
                  snd_addr_d = bus.snd_alt ? ADDR_W'(SND_ALT) : ADDR_W'(SND_MAIN);
                  swap_d     = 1'b0;
               end else begin
                  if (hb_fall) snd_addr_d = snd_addr_q + ADDR_W'(2);
                  if (vb_fall) swap_d = 1'b1;
               end
            end
            2'd1: begin
               gnt_vld_d = pick_vld;
               gnt_d     = pick;
`ifndef DIO_FIXED_PRIO_EN
               if (pick_vld) last_d = pick;
`endif
            end
            2'd2:    gnt_vld_d = 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         slot_q      <= 2'd0;
         vbd_q       <= 1'b1;
         hbd_q       <= 1'b1;
         swap_q      <= 1'b0;
         audio_req_q <= 1'b0;
         snd_addr_q  <= ADDR_W'(SND_MAIN);
         gnt_vld_q   <= 1'b0;
         gnt_q       <= '0;
`ifndef DIO_FIXED_PRIO_EN
         last_q      <= GW'(NUM_DIO - 1);
`endif
      end else begin
         slot_q      <= slot_d;
         vbd_q       <= vbd_d;
         hbd_q       <= hbd_d;
         swap_q      <= swap_d;
         audio_req_q <= audio_req_d;
         snd_addr_q  <= snd_addr_d;
         gnt_vld_q   <= gnt_vld_d;
         gnt_q       <= gnt_d;
`ifndef DIO_FIXED_PRIO_EN
         last_q      <= last_d;
`endif
      end
   end

   assign cpu_ctl  = (slot_q == 2'd1) | (bus.turbo & (slot_q == 2'd3));
   assign load_snd = audio_req_q & (slot_q == 2'd0);
   assign dio_a    = bus.dio_addr[int'(gnt_q) * ADDR_W +: ADDR_W];
   assign dio_off  = ADDR_W'(int'(gnt_q) + 1) * ADDR_W'(DIO_BASE_STEP);

   always_comb begin
      bus.dio_ack = '0;
      if (gnt_vld_q) bus.dio_ack[gnt_q] = 1'b1;
   end

   always_comb begin
      if (gnt_vld_q)
         bus.mem_addr = dio_a + dio_off;
      else if (load_snd)
         bus.mem_addr = ADDR_W'(mask_ram(snd_addr_q[21:0], bus.cfg_ram_size));
      else if (cpu_ctl & bus.sel_rom)
         bus.mem_addr = ADDR_W'(mask_rom(bus.cpu_addr[21:0], bus.cfg_rom_128k));
      else if (cpu_ctl & bus.sel_ram)
         bus.mem_addr = ADDR_W'(mask_ram(bus.cpu_addr[21:0], bus.cfg_ram_size));
      else
         bus.mem_addr = ADDR_W'(bus.cpu_addr[21:0]);
   end

   assign bus.slot        = slot_q;
   assign bus.cpu_bus_ctl = cpu_ctl;
   assign bus.dio_bus_ctl = (slot_q == 2'd2);
   assign bus.load_sound  = load_snd;
   assign bus.rom_oe_n    = ~(gnt_vld_q | (cpu_ctl & bus.sel_rom & bus.cpu_rw));
   assign bus.ram_oe_n    = ~(load_snd | (cpu_ctl & bus.sel_ram & bus.cpu_rw));
   assign bus.ram_we_n    = ~(cpu_ctl & bus.sel_ram & ~bus.cpu_rw);
   assign bus.mem_uds_n   = cpu_ctl ? bus.cpu_uds_n : 1'b0;
   assign bus.mem_lds_n   = cpu_ctl ? bus.cpu_lds_n : 1'b0;
endmodule

// File: tb/tb_mem_slot_scheduler.sv
// Directed bench for mem_slot_scheduler: slots, DIO arbitration, sound addressing, masking, reset.
// Expectations follow DIO_FIXED_PRIO_EN when the bench is built with it.
module tb_mem_slot_scheduler;
   localparam int ADDR_W  = 22;
   localparam int NUM_DIO = 2;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   mem_slot_if #(.ADDR_W(ADDR_W), .NUM_DIO(NUM_DIO)) bus ();

   mem_slot_scheduler #(.ADDR_W(ADDR_W), .NUM_DIO(NUM_DIO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic tick_cep();
      @(negedge clk);
      bus.cep = 1'b1;
      @(negedge clk);
      bus.cep = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.cep = 0; bus.turbo = 0; bus.cfg_rom_128k = 0; bus.cfg_ram_size = 2'd3;
      bus.cpu_addr = 24'h001234; bus.cpu_uds_n = 1; bus.cpu_lds_n = 1; bus.cpu_rw = 1;
      bus.sel_ram = 0; bus.sel_rom = 0; bus.vblank_n = 1; bus.hblank_n = 1; bus.snd_alt = 0;
      bus.dio_req = '0; bus.dio_addr = '0;
      do_reset();
      n_cmp++; if (bus.slot !== 2'd0) begin n_err++; $display("FAIL reset_slot got=%0h exp=0", bus.slot); end
      n_cmp++; if (bus.dio_ack !== 2'b00) begin n_err++; $display("FAIL reset_ack got=%b exp=00", bus.dio_ack); end
      n_cmp++; if ({bus.cpu_bus_ctl, bus.dio_bus_ctl, bus.load_sound} !== 3'b000) begin
         n_err++; $display("FAIL reset_ctl got=%b exp=000", {bus.cpu_bus_ctl, bus.dio_bus_ctl, bus.load_sound}); end
      n_cmp++; if ({bus.rom_oe_n, bus.ram_oe_n, bus.ram_we_n} !== 3'b111) begin
         n_err++; $display("FAIL reset_en got=%b exp=111", {bus.rom_oe_n, bus.ram_oe_n, bus.ram_we_n}); end
      n_cmp++; if ({bus.mem_uds_n, bus.mem_lds_n} !== 2'b00) begin
         n_err++; $display("FAIL reset_strb got=%b exp=00", {bus.mem_uds_n, bus.mem_lds_n}); end
      n_cmp++; if (bus.mem_addr !== 22'h001234) begin n_err++; $display("FAIL reset_addr got=%h exp=001234", bus.mem_addr); end
   endtask

   task automatic test_slots();
      logic [1:0] es;
      for (int t = 0; t < 2; t++) begin
         bus.turbo = t[0];
         for (int i = 0; i < 4; i++) begin
            es = 2'(i);
            n_cmp++; if (bus.slot !== es) begin n_err++; $display("FAIL slot_seq got=%0d exp=%0d", bus.slot, es); end
            n_cmp++; if (bus.cpu_bus_ctl !== ((i == 1) || (t == 1 && i == 3))) begin
               n_err++; $display("FAIL cpu_ctl t=%0d slot=%0d got=%b", t, i, bus.cpu_bus_ctl); end
            n_cmp++; if (bus.dio_bus_ctl !== (i == 2)) begin
               n_err++; $display("FAIL dio_ctl slot=%0d got=%b", i, bus.dio_bus_ctl); end
            tick_cep();
         end
      end
      bus.turbo = 0;
   endtask

   task automatic test_dio_arb();
      logic [1:0]  exp_ack [3];
      logic [21:0] ea;
`ifdef DIO_FIXED_PRIO_EN
      exp_ack = '{2'b01, 2'b01, 2'b01};
`else
      exp_ack = '{2'b01, 2'b10, 2'b01};
`endif
      do_reset();
      bus.dio_addr = {22'h000010, 22'h000020};
      bus.dio_req  = 2'b11;
      for (int r = 0; r < 3; r++) begin
         tick_cep();
         n_cmp++; if (bus.dio_ack !== 2'b00) begin n_err++; $display("FAIL dio_ack_slot1 got=%b exp=00", bus.dio_ack); end
         tick_cep();
         ea = (exp_ack[r] == 2'b01) ? 22'h100020 : 22'h200010;
         n_cmp++; if (bus.dio_ack !== exp_ack[r]) begin n_err++; $display("FAIL dio_ack r=%0d got=%b exp=%b", r, bus.dio_ack, exp_ack[r]); end
         n_cmp++; if (bus.mem_addr !== ea) begin n_err++; $display("FAIL dio_addr r=%0d got=%h exp=%h", r, bus.mem_addr, ea); end
         n_cmp++; if (bus.rom_oe_n !== 1'b0) begin n_err++; $display("FAIL dio_rom_oe got=%b exp=0", bus.rom_oe_n); end
         tick_cep();
         n_cmp++; if (bus.dio_ack !== 2'b00) begin n_err++; $display("FAIL dio_ack_slot3 got=%b exp=00", bus.dio_ack); end
         tick_cep();
      end
      bus.dio_req = 2'b00;
      tick_cep();
      tick_cep();
      n_cmp++; if (bus.dio_ack !== 2'b00) begin n_err++; $display("FAIL dio_noreq_ack got=%b exp=00", bus.dio_ack); end
      n_cmp++; if (bus.rom_oe_n !== 1'b1) begin n_err++; $display("FAIL dio_noreq_oe got=%b exp=1", bus.rom_oe_n); end
      tick_cep();
      tick_cep();
   endtask

   task automatic sound_round(input logic vb, input logic hb);
      bus.vblank_n = vb;
      bus.hblank_n = hb;
      for (int i = 0; i < 4; i++) tick_cep();
   endtask

   task automatic test_sound();
      do_reset();
      bus.cfg_ram_size = 2'd3;
      bus.snd_alt = 0;
      sound_round(1'b0, 1'b1);
      n_cmp++; if (bus.load_sound !== 1'b0) begin n_err++; $display("FAIL snd_vb_only got=%b exp=0", bus.load_sound); end
      sound_round(1'b0, 1'b0);
      n_cmp++; if (bus.load_sound !== 1'b1) begin n_err++; $display("FAIL snd_load1 got=%b exp=1", bus.load_sound); end
      n_cmp++; if (bus.mem_addr !== 22'h3FFD00) begin n_err++; $display("FAIL snd_main got=%h exp=3ffd00", bus.mem_addr); end
      n_cmp++; if (bus.ram_oe_n !== 1'b0) begin n_err++; $display("FAIL snd_ram_oe got=%b exp=0", bus.ram_oe_n); end
      tick_cep();
      n_cmp++; if (bus.load_sound !== 1'b0) begin n_err++; $display("FAIL snd_slot1 got=%b exp=0", bus.load_sound); end
      for (int i = 0; i < 3; i++) tick_cep();
      sound_round(1'b1, 1'b1);
      n_cmp++; if (bus.load_sound !== 1'b0) begin n_err++; $display("FAIL snd_idle got=%b exp=0", bus.load_sound); end
      sound_round(1'b1, 1'b0);
      n_cmp++; if (bus.mem_addr !== 22'h3FFD02) begin n_err++; $display("FAIL snd_inc got=%h exp=3ffd02", bus.mem_addr); end
      sound_round(1'b1, 1'b1);
      bus.snd_alt = 1;
      sound_round(1'b0, 1'b0);
      n_cmp++; if (bus.mem_addr !== 22'h3FA100) begin n_err++; $display("FAIL snd_alt got=%h exp=3fa100", bus.mem_addr); end
      n_cmp++; if (bus.load_sound !== 1'b1) begin n_err++; $display("FAIL snd_load_alt got=%b exp=1", bus.load_sound); end
      bus.snd_alt = 0; bus.vblank_n = 1; bus.hblank_n = 1;
   endtask

   task automatic test_cpu_mask();
      do_reset();
      tick_cep();
      bus.sel_ram = 1; bus.sel_rom = 0; bus.cpu_rw = 1; bus.cfg_ram_size = 2'd0;
      bus.cpu_addr = 24'h3E1234; bus.cpu_uds_n = 0; bus.cpu_lds_n = 1;
      #1;
      n_cmp++; if (bus.mem_addr !== 22'h001234) begin n_err++; $display("FAIL ram128k got=%h exp=001234", bus.mem_addr); end
      n_cmp++; if ({bus.ram_oe_n, bus.ram_we_n, bus.rom_oe_n} !== 3'b011) begin
         n_err++; $display("FAIL ram_rd_en got=%b exp=011", {bus.ram_oe_n, bus.ram_we_n, bus.rom_oe_n}); end
      n_cmp++; if ({bus.mem_uds_n, bus.mem_lds_n} !== 2'b01) begin
         n_err++; $display("FAIL cpu_strb got=%b exp=01", {bus.mem_uds_n, bus.mem_lds_n}); end
      bus.cfg_ram_size = 2'd1; #1;
      n_cmp++; if (bus.mem_addr !== 22'h061234) begin n_err++; $display("FAIL ram512k got=%h exp=061234", bus.mem_addr); end
      bus.cfg_ram_size = 2'd2; #1;
      n_cmp++; if (bus.mem_addr !== 22'h0E1234) begin n_err++; $display("FAIL ram1m got=%h exp=0e1234", bus.mem_addr); end
      bus.cfg_ram_size = 2'd3; bus.cpu_rw = 0; #1;
      n_cmp++; if (bus.mem_addr !== 22'h3E1234) begin n_err++; $display("FAIL ram4m got=%h exp=3e1234", bus.mem_addr); end
      n_cmp++; if ({bus.ram_oe_n, bus.ram_we_n} !== 2'b10) begin
         n_err++; $display("FAIL ram_wr_en got=%b exp=10", {bus.ram_oe_n, bus.ram_we_n}); end
      bus.sel_ram = 0; bus.sel_rom = 1; bus.cpu_rw = 1; bus.cfg_rom_128k = 0; bus.cpu_addr = 24'h41ABCD; #1;
      n_cmp++; if (bus.mem_addr !== 22'h02ABCD) begin n_err++; $display("FAIL rom64k got=%h exp=02abcd", bus.mem_addr); end
      n_cmp++; if (bus.rom_oe_n !== 1'b0) begin n_err++; $display("FAIL rom_oe got=%b exp=0", bus.rom_oe_n); end
      bus.cfg_rom_128k = 1; #1;
      n_cmp++; if (bus.mem_addr !== 22'h01ABCD) begin n_err++; $display("FAIL rom128k got=%h exp=01abcd", bus.mem_addr); end
      bus.sel_rom = 0; bus.cpu_uds_n = 1; bus.cpu_lds_n = 1; bus.cfg_rom_128k = 0;
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      bus.dio_addr = {22'h000010, 22'h000020};
      bus.dio_req = 2'b10;
      tick_cep();
      tick_cep();
      n_cmp++; if (bus.dio_ack !== 2'b10) begin n_err++; $display("FAIL mid_ack got=%b exp=10", bus.dio_ack); end
      bus.dio_req = 2'b00;
      @(negedge clk);
      n_cmp++; if (bus.dio_ack !== 2'b10) begin n_err++; $display("FAIL mid_hold got=%b exp=10", bus.dio_ack); end
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.dio_ack !== 2'b00) begin n_err++; $display("FAIL mid_rst_ack got=%b exp=00", bus.dio_ack); end
      n_cmp++; if (bus.slot !== 2'd0) begin n_err++; $display("FAIL mid_rst_slot got=%0d exp=0", bus.slot); end
      reset = 1'b0;
      bus.dio_req = 2'b11;
      tick_cep();
      tick_cep();
      n_cmp++; if (bus.dio_ack !== 2'b01) begin n_err++; $display("FAIL post_rst_ack got=%b exp=01", bus.dio_ack); end
      bus.dio_req = 2'b00;
   endtask

   initial begin
      test_reset();
      test_slots();
      test_dio_arb();
      test_sound();
      test_cpu_mask();
      test_reset_mid_grant();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mem_slot_scheduler.md
Name: mem_slot_scheduler

Overview:
Time-division memory slot scheduler between the 68000 core and the shared RAM/ROM. It serves the CPU, a sound-fetch engine and NUM_DIO disk/DMA read channels. DIO channels use a request/acknowledge handshake with arbitration, replacing fixed sub-cycle ownership. Output address, strobes and enables drive the SDRAM/ROM controller directly. The block sits between the CPU bus, the address decoder outputs and the memory controller.

Parameters:
ADDR_W, 22, memory address width; must be ≥ 22; bits above 21 are driven 0.
NUM_DIO, 2, number of DIO read channels, 1..8.
DIO_BASE_STEP, 22'h100000, channel i's address is offset by (i+1)*DIO_BASE_STEP.
SND_MAIN, 22'h3FFD00, main sound buffer start.
SND_ALT, 22'h3FA100, alternate sound buffer start.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous active-high reset.
cep  in  1  slot advance enable, 8.125 MHz pulse.
turbo  in  1  1 = CPU also owns slot 3.
cfg_rom_128k  in  1  0 = 64K ROM, 1 = 128K ROM.
cfg_ram_size  in  2  0=128K, 1=512K, 2=1MB, 3=4MB.
cpu_addr  in  24  CPU address.
cpu_uds_n, cpu_lds_n, cpu_rw  in  1 each  CPU strobes.
sel_ram, sel_rom  in  1 each  decoder selects for cpu_addr.
vblank_n, hblank_n  in  1 each  video blanking, active low.
snd_alt  in  1  selects the alternate sound buffer.
dio_req  in  NUM_DIO  per-channel read request.
dio_addr  in  NUM_DIO*ADDR_W  per-channel address; channel i occupies bits [i*ADDR_W +: ADDR_W].
dio_ack  out  NUM_DIO  one-hot grant; data is valid at the end of the slot.
slot  out  2  current slot number.
cpu_bus_ctl, dio_bus_ctl, load_sound  out  1 each  slot ownership.
mem_addr  out  ADDR_W  memory address.
mem_uds_n, mem_lds_n  out  1 each  byte strobes.
rom_oe_n, ram_oe_n, ram_we_n  out  1 each  memory enables, active low.

Behaviour:
- slot: 2-bit register; increments mod 4 on each cep. Reset sets it to 0.
- Slot ownership:
  - slot 0: sound.
  - slot 1: CPU.
  - slot 2: DIO.
  - slot 3: CPU when turbo=1; otherwise idle, with all enables inactive.
- cpu_bus_ctl = (slot==1) | (turbo & slot==3). dio_bus_ctl = (slot==2).
- Sound engine, evaluated on the cep that moves slot 0→1:
  - Sample vblank_n and hblank_n into the registers vbD and hbD.
  - Falling vblank_n (vbD=1, vblank_n=0) sets the swap flag.
  - Falling hblank_n: if swap (or a vblank fall in the same sample), snd_addr ← snd_alt ? SND_ALT : SND_MAIN and swap ← 0. Otherwise snd_addr ← snd_addr+2, wrapping mod 2^ADDR_W.
  - audio_req ← 1 on a falling hblank_n, else 0.
  - load_sound = audio_req & (slot==0).
- DIO arbitration, on the cep that moves slot 1→2:
  - grant ← first requesting channel, searched round-robin starting at last_grant+1 and wrapping. The pointer last_grant then updates to grant.
  - With no requests: no grant, and last_grant is unchanged.
  - dio_ack[grant] is held high for all of slot 2 and drops on entry to slot 3.
  - A requester must hold dio_req and dio_addr stable until it sees ack.
  - dio_req deasserting during slot 2 does not cancel the grant.
- mem_addr priority:
  1. DIO grant: dio_addr[g] + (g+1)*DIO_BASE_STEP, truncated to ADDR_W.
  2. load_sound: snd_addr.
  3. Otherwise: cpu_addr[21:0] with size masking.
- Size masking, RAM access (sound, or cpu_bus_ctl & sel_ram):
  - cfg_ram_size=0 forces A17..A21 to 0.
  - cfg_ram_size=1 forces A19..A21 to 0.
  - cfg_ram_size=2 forces A20..A21 to 0.
  - cfg_ram_size=3 applies no forcing.
- Size masking, ROM access (cpu_bus_ctl & sel_rom):
  - 64K ROM: A16=0, A17=1, A18..A21=0.
  - 128K ROM: A17..A21=0.
- Enables:
  - rom_oe_n = ~(dio grant active | cpu_bus_ctl&sel_rom&cpu_rw).
  - ram_oe_n = ~(load_sound | cpu_bus_ctl&sel_ram&cpu_rw).
  - ram_we_n = ~(cpu_bus_ctl&sel_ram&~cpu_rw).
  - mem_uds_n/mem_lds_n follow the CPU strobes in CPU slots and are 0 otherwise.
- Reset values: slot=0, audio_req=0, swap=0, vbD=hbD=1, snd_addr=SND_MAIN, no grant, last_grant=NUM_DIO-1.
- Resulting outputs after reset: dio_ack=0, cpu_bus_ctl=0, dio_bus_ctl=0, load_sound=0, rom_oe_n=ram_oe_n=ram_we_n=1, mem_uds_n=mem_lds_n=0, mem_addr=cpu_addr masked.
- Reset mid-grant drops ack in the next cycle; the requester must reissue.

Optional Feature:
DIO_FIXED_PRIO_EN:
- Defined: arbitration is fixed priority, lowest channel index wins, and last_grant is unused.
- Undefined: round-robin arbitration as described under Behaviour.

Test Plan:
- Reset, 4 ceps with turbo=0 → slot sequence 0,1,2,3; cpu_bus_ctl high only in slot 1. With turbo=1 → cpu_bus_ctl high in slots 1 and 3.
- dio_req=2'b11 held for 3 rounds (round-robin) → acks ch0, ch1, ch0. Ch1 with dio_addr=0x000010 gives mem_addr=0x200010 in slot 2, and rom_oe_n=0 in that slot.
- vblank_n fall, then hblank_n fall, snd_alt=0 → load_sound in the next slot 0 with mem_addr=0x3FFD00. Next hblank fall → 0x3FFD02. With snd_alt=1 after a vblank → 0x3FA100.
- CPU read with cfg_ram_size=0, sel_ram, cpu_addr=0x3E1234 → mem_addr=0x001234, ram_oe_n=0. With cfg_rom_128k=0, sel_rom, cpu_addr=0x41ABCD → mem_addr=0x02ABCD.
- Assert reset while dio_ack[1]=1 → ack 0 next cycle, slot=0. First grant after reset goes to ch0.
- DIO_FIXED_PRIO_EN defined, dio_req=2'b11 for 3 rounds → ch0 acked every round.
